// File: rtl/ex_stage_if.sv
// ex_stage_if: data RAM request bus driven by the execute stage.
//   data_sram_en    : access enable
//   data_sram_wen   : byte write enables (0 = read)
//   data_sram_addr  : byte address (ALU result)
//   data_sram_wdata : store data
// master = execute stage, slave = data RAM / memory side.
interface ex_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata
  );

  modport slave (
    input data_sram_en,
    input data_sram_wen,
    input data_sram_addr,
    input data_sram_wdata
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS-style execute stage.
// Registers the ID/EX bus, runs the ALU, drives the data RAM request,
// forwards the result to decode and passes the instruction on to MEM.
// Optional multi-cycle divider with HI/LO registers, built only when the
// macro EX_DIV_EN is defined; otherwise div/divu are no-ops and HI/LO read 0.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall[5:0]      : pipeline stall vector (bit 2 = ID/EX, bit 3 = EX/MEM)
//   id_to_ex_bus    : 159-bit decoded instruction from ID
//   ex_to_mem_bus   : 76-bit {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_rf_bus    : 38-bit {rf_we, rf_waddr, ex_result} forwarding path
//   ex_id           : load in EX (registered sel_rf_res)
//   data_sram       : data RAM request bus (ex_stage_if.master)
//   stallreq_for_ex : divider busy stall request
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         ex_id,
  ex_stage_if.master   data_sram,
  output logic         stallreq_for_ex
);

  logic [158:0] id_to_ex_r;

  // ID/EX register: a stalled ID feeding a running EX inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_r <= '0;
    end else if (stall[2] && !stall[3]) begin
      id_to_ex_r <= '0;
    end else if (!stall[2]) begin
      id_to_ex_r <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  sel_alu_src1;
  logic [3:0]  sel_alu_src2;
  logic        data_ram_en, rf_we, sel_rf_res;
  logic [3:0]  data_ram_wen;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, sel_alu_src1, sel_alu_src2, data_ram_en, data_ram_wen,
          rf_we, rf_waddr, sel_rf_res, rs_data, rt_data} = id_to_ex_r;

  logic [5:0] opcode, func;
  assign opcode = inst[31:26];
  assign func   = inst[5:0];

  logic is_mfhi, is_mflo;
  assign is_mfhi = (opcode == 6'h00) && (func == 6'h10);
  assign is_mflo = (opcode == 6'h00) && (func == 6'h12);

  // Operand selection
  logic [31:0] src1, src2;
  always_comb begin
    src1 = '0;
    if (sel_alu_src1[0]) src1 = rs_data;
    else if (sel_alu_src1[1]) src1 = pc;
    else if (sel_alu_src1[2]) src1 = {27'd0, inst[10:6]};
  end

  always_comb begin
    src2 = '0;
    if (sel_alu_src2[0]) src2 = rt_data;
    else if (sel_alu_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
    else if (sel_alu_src2[2]) src2 = 32'd8;
    else if (sel_alu_src2[3]) src2 = {16'd0, inst[15:0]};
  end

  // ALU, alu_op one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}
  logic [31:0] alu_result;
  always_comb begin
    alu_result = '0;
    if (alu_op[11])     alu_result = src1 + src2;
    else if (alu_op[10]) alu_result = src1 - src2;
    else if (alu_op[9])  alu_result = {31'd0, $signed(src1) < $signed(src2)};
    else if (alu_op[8])  alu_result = {31'd0, src1 < src2};
    else if (alu_op[7])  alu_result = src1 & src2;
    else if (alu_op[6])  alu_result = ~(src1 | src2);
    else if (alu_op[5])  alu_result = src1 | src2;
    else if (alu_op[4])  alu_result = src1 ^ src2;
    else if (alu_op[3])  alu_result = src2 << src1[4:0];
    else if (alu_op[2])  alu_result = src2 >> src1[4:0];
    else if (alu_op[1])  alu_result = $unsigned($signed(src2) >>> src1[4:0]);
    else if (alu_op[0])  alu_result = {src2[15:0], 16'd0};
  end

  logic [31:0] hi, lo;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  div_state_t  state, state_nxt;
  logic        is_div, div_signed;
  logic [4:0]  div_cnt;
  logic [31:0] div_q, div_r, div_d;
  logic        neg_q, neg_r;
  logic [32:0] partial, trial;

  assign is_div     = (opcode == 6'h00) && ((func == 6'h1A) || (func == 6'h1B));
  assign div_signed = (func == 6'h1A);

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    stallreq_for_ex = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_div) begin
          stallreq_for_ex = 1'b1;
          state_nxt       = (rt_data == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        stallreq_for_ex = 1'b1;
        if (div_cnt == 5'd31) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Restoring step: the dividend is shifted out of div_q into the
  // partial remainder while quotient bits are shifted in behind it.
  always_comb begin
    partial = {div_r, div_q[31]};
    trial   = partial - {1'b0, div_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      div_q   <= '0;
      div_r   <= '0;
      div_d   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            div_cnt <= '0;
            div_q   <= mag(rs_data, div_signed);
            div_r   <= '0;
            div_d   <= mag(rt_data, div_signed);
            neg_q   <= div_signed && (rs_data[31] ^ rt_data[31]);
            neg_r   <= div_signed && rs_data[31];
          end
        end
        S_RUN: begin
          div_cnt <= div_cnt + 5'd1;
          if (!trial[32]) begin
            div_r <= trial[31:0];
            div_q <= {div_q[30:0], 1'b1};
          end else begin
            div_r <= partial[31:0];
            div_q <= {div_q[30:0], 1'b0};
          end
        end
        S_DONE: begin
          // A zero divisor skipped RUN with div_d = 0: HI/LO stay untouched.
          if (div_d != 32'd0) begin
            lo <= neg_q ? -div_q : div_q;
            hi <= neg_r ? -div_r : div_r;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign hi              = '0;
  assign lo              = '0;
  assign stallreq_for_ex = 1'b0;
`endif

  // Result / writeback selection
  logic [31:0] ex_result;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;

  always_comb begin
    ex_result   = alu_result;
    ex_rf_we    = rf_we;
    ex_rf_waddr = rf_waddr;
    if (is_mfhi || is_mflo) begin
      ex_result   = is_mfhi ? hi : lo;
      ex_rf_we    = 1'b1;
      ex_rf_waddr = inst[15:11];
    end
  end

  assign ex_to_mem_bus = {pc, data_ram_en, data_ram_wen, sel_rf_res, ex_rf_we, ex_rf_waddr, ex_result};
  assign ex_to_rf_bus  = {ex_rf_we, ex_rf_waddr, ex_result};
  assign ex_id         = sel_rf_res;

  assign data_sram.data_sram_en    = data_ram_en;
  assign data_sram.data_sram_wen   = data_ram_wen;
  assign data_sram.data_sram_addr  = alu_result;
  assign data_sram.data_sram_wdata = rt_data;

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         ex_id;
  logic         stallreq_for_ex;

  ex_stage_if sram_bus ();

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .ex_id           (ex_id),
    .data_sram       (sram_bus),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200,
                          OP_SLTU = 12'h100, OP_AND = 12'h080, OP_NOR = 12'h040,
                          OP_OR = 12'h020, OP_XOR = 12'h010, OP_SLL = 12'h008,
                          OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI = 12'h001;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic ren,
      input logic [3:0] rwen, input logic we, input logic [4:0] wa, input logic selres,
      input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ren, rwen, we, wa, selres, rs, rt};
  endfunction

  function automatic logic [158:0] alu_rr(input logic [11:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt);
    return mk(32'h0, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, op, 3'b001, 4'b0001,
              1'b0, 4'h0, 1'b1, 5'd3, 1'b0, rs, rt);
  endfunction

  function automatic logic [158:0] div_bus(input logic [5:0] fn, input logic [31:0] rs,
                                           input logic [31:0] rt);
    return mk(32'h0, {6'h00, 5'd8, 5'd9, 10'd0, fn}, 12'd0, 3'b001, 4'b0001,
              1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt);
  endfunction

  function automatic logic [158:0] mf_bus(input logic [5:0] fn, input logic [4:0] rd);
    return mk(32'h0, {6'h00, 10'd0, rd, 5'd0, fn}, 12'd0, 3'b000, 4'b0000,
              1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
  endfunction

  task automatic apply(input logic [158:0] b);
    id_to_ex_bus = b;
    stall        = 6'b000000;
    tick();
  endtask

  task automatic alu_vec(input string tag, input logic [11:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    apply(alu_rr(op, a, b));
    check(tag, {96'd0, ex_to_rf_bus[31:0]}, {96'd0, exp});
  endtask

`ifdef EX_DIV_EN
  // Holds EX stalled while the divider asks for it; returns the number of
  // stall-request cycles. next_b enters EX on the edge that ends DONE.
  task automatic run_div(input logic [158:0] div_b, input logic [158:0] next_b,
                         output int cycles);
    apply(div_b);
    id_to_ex_bus = next_b;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stallreq_for_ex) break;
      cycles++;
      stall = 6'b001111;
      tick();
    end
    stall = 6'b000000;
    tick();
  endtask
`endif

  initial begin
    rst          = 1'b1;
    stall        = 6'b000000;
    id_to_ex_bus = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_mem_bus", {52'd0, ex_to_mem_bus}, 128'd0);
    check("rst_rf_bus", {90'd0, ex_to_rf_bus}, 128'd0);
    check("rst_misc", {123'd0, ex_id, sram_bus.data_sram_en, sram_bus.data_sram_wen != 4'h0,
                       stallreq_for_ex, sram_bus.data_sram_wdata != 32'h0}, 128'd0);
    check("rst_addr", {96'd0, sram_bus.data_sram_addr}, 128'd0);

    // addu overflow wraps, forwarded in the same cycle
    apply(mk(32'hBFC00000, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, OP_ADD, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h7FFFFFFF, 32'h1));
    check("addu_rf_bus", {90'd0, ex_to_rf_bus}, {90'd0, 1'b1, 5'd3, 32'h80000000});
    check("addu_mem_bus", {52'd0, ex_to_mem_bus},
          {52'd0, 32'hBFC00000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h80000000});

    // ID/EX hold: both stages stalled, content unchanged
    id_to_ex_bus = alu_rr(OP_SUB, 32'd1, 32'd1);
    stall        = 6'b001100;
    tick();
    check("hold", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'h80000000});

    // lw with negative offset
    apply(mk(32'h0, {6'h23, 5'd1, 5'd2, 16'hFFFC}, OP_ADD, 3'b001, 4'b0010,
             1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h00001000, 32'h0));
    check("lw_addr", {96'd0, sram_bus.data_sram_addr}, {96'd0, 32'h00000FFC});
    check("lw_ctl", {121'd0, sram_bus.data_sram_en, sram_bus.data_sram_wen, ex_id, stallreq_for_ex},
          {121'd0, 1'b1, 4'h0, 1'b1, 1'b0});

    // bubble: ID stalled, EX running
    id_to_ex_bus = alu_rr(OP_ADD, 32'd5, 32'd6);
    stall        = 6'b000100;
    tick();
    check("bubble_mem_bus", {52'd0, ex_to_mem_bus}, 128'd0);
    check("bubble_sram_en", {127'd0, sram_bus.data_sram_en}, 128'd0);

    // sw
    apply(mk(32'h0, {6'h2B, 5'd1, 5'd2, 16'h0008}, OP_ADD, 3'b001, 4'b0010,
             1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h00000100, 32'hDEADBEEF));
    check("sw_req", {59'd0, sram_bus.data_sram_en, sram_bus.data_sram_wen,
                     sram_bus.data_sram_addr, sram_bus.data_sram_wdata},
          {59'd0, 1'b1, 4'hF, 32'h00000108, 32'hDEADBEEF});

    alu_vec("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFFFFFE);
    alu_vec("slt", OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu_vec("sltu", OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu_vec("and", OP_AND, 32'hF0F01234, 32'h0FF000FF, 32'h00F00034);
    alu_vec("or", OP_OR, 32'hF0F01234, 32'h0FF000FF, 32'hFFF012FF);
    alu_vec("xor", OP_XOR, 32'hF0F01234, 32'h0FF000FF, 32'hFF0012CB);
    alu_vec("nor", OP_NOR, 32'hF0F01234, 32'h0FF000FF, 32'h000FED00);

    // shifts by sa field (inst[10:6] = 4)
    begin
      logic [11:0] ops [3];
      logic [31:0] exps [3];
      ops  = '{OP_SLL, OP_SRL, OP_SRA};
      exps = '{32'h00000010, 32'h08000000, 32'hF8000000};
      for (int i = 0; i < 3; i++) begin
        apply(mk(32'h0, {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00}, ops[i], 3'b100, 4'b0001,
                 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h80000001));
        check($sformatf("shift%0d", i), {96'd0, ex_to_rf_bus[31:0]}, {96'd0, exps[i]});
      end
    end

    // lui, zero-extended immediate
    apply(mk(32'h0, {6'h0F, 5'd0, 5'd2, 16'h1234}, OP_LUI, 3'b000, 4'b1000,
             1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0));
    check("lui", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'h12340000});

    // ori: zero-extended imm
    apply(mk(32'h0, {6'h0D, 5'd1, 5'd2, 16'h8000}, OP_OR, 3'b001, 4'b1000,
             1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h00000001, 32'h0));
    check("ori_zext", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'h00008001});

    // jal link value: pc + 8
    apply(mk(32'hBFC00100, {6'h03, 26'd0}, OP_ADD, 3'b010, 4'b0100,
             1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0));
    check("jal_link", {90'd0, ex_to_rf_bus}, {90'd0, 1'b1, 5'd31, 32'hBFC00108});

`ifdef EX_DIV_EN
    begin
      int cyc;
      run_div(div_bus(6'h1A, 32'd7, 32'hFFFFFFFE), mf_bus(6'h12, 5'd4), cyc);
      check("div_stall_cycles", 128'(cyc), 128'd33);
      check("div_mflo", {90'd0, ex_to_rf_bus}, {90'd0, 1'b1, 5'd4, 32'hFFFFFFFD});
      apply(mf_bus(6'h10, 5'd5));
      check("div_mfhi", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'd1});

      run_div(div_bus(6'h1A, 32'hFFFFFFF9, 32'd2), mf_bus(6'h10, 5'd4), cyc);
      check("div_neg_rem", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'hFFFFFFFF});

      run_div(div_bus(6'h1B, 32'hFFFFFFFE, 32'd2), mf_bus(6'h12, 5'd4), cyc);
      check("divu_quot", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'h7FFFFFFF});

      run_div(div_bus(6'h1B, 32'd5, 32'd7), mf_bus(6'h10, 5'd4), cyc);
      check("divu_rem5", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'd5});

      run_div(div_bus(6'h1B, 32'd9, 32'd0), mf_bus(6'h10, 5'd4), cyc);
      check("div0_stall_cycles", 128'(cyc), 128'd1);
      check("div0_hi_kept", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'd5});

      run_div(div_bus(6'h1B, 32'd100, 32'd7), mf_bus(6'h12, 5'd4), cyc);
      check("divu_lo14", {96'd0, ex_to_rf_bus[31:0]}, {96'd0, 32'd14});

      // reset in the middle of RUN
      apply(div_bus(6'h1A, 32'd1000, 32'd3));
      stall = 6'b001111;
      for (int i = 0; i < 10; i++) tick();
      check("run_stallreq", {127'd0, stallreq_for_ex}, {127'd0, 1'b1});
      rst          = 1'b1;
      id_to_ex_bus = '0;
      tick();
      rst   = 1'b0;
      stall = 6'b000000;
      #1;
      check("rst_run_stallreq", {127'd0, stallreq_for_ex}, 128'd0);
      apply(mf_bus(6'h10, 5'd4));
      check("rst_run_hi", {96'd0, ex_to_rf_bus[31:0]}, 128'd0);
      apply(mf_bus(6'h12, 5'd4));
      check("rst_run_lo", {96'd0, ex_to_rf_bus[31:0]}, 128'd0);
      check("rst_run_stallreq2", {127'd0, stallreq_for_ex}, 128'd0);
    end
`else
    apply(div_bus(6'h1A, 32'd7, 32'hFFFFFFFE));
    check("nodiv_stallreq", {127'd0, stallreq_for_ex}, 128'd0);
    check("nodiv_rf_we", {127'd0, ex_to_rf_bus[37]}, 128'd0);
    apply(mf_bus(6'h12, 5'd4));
    check("nodiv_mflo", {90'd0, ex_to_rf_bus}, {90'd0, 1'b1, 5'd4, 32'd0});
    apply(mf_bus(6'h10, 5'd6));
    check("nodiv_mfhi", {90'd0, ex_to_rf_bus}, {90'd0, 1'b1, 5'd6, 32'd0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Port list:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  StallBus  pipeline stall vector; bit 2 = ID/EX register, bit 3 = EX/MEM register
- id_to_ex_bus  in  ID_TO_EX_WD (159)  {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_data[63:32], rt_data[31:0]}
- ex_to_mem_bus  out  76  {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
- ex_to_rf_bus  out  EX_TO_RF_WD (38)  {rf_we, rf_waddr, ex_result}, forwarding path to decode
- ex_id  out  1  registered sel_rf_res; load in EX
- data_sram_en  out  1  data RAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  data RAM address
- data_sram_wdata  out  32  store data
- stallreq_for_ex  out  1  divider busy stall request

Function
REQ-003 Input register: stall[2]=Stop and stall[3]=NoStop loads all-zero (bubble); stall[2]=NoStop loads id_to_ex_bus; otherwise it holds.
REQ-004 src1 SHALL be rs_data (sel[0]), pc (sel[1]), or zero-extended inst[10:6] (sel[2]); src2 SHALL be rt_data (sel[0]), sign-extended imm (sel[1]), 32'd8 (sel[2]), or zero-extended imm (sel[3]).
REQ-005 ALU SHALL implement alu_op one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}; shifts use src2 shifted by src1[4:0]; lui = {src2[15:0], 16'b0}; add/sub wrap modulo 2^32, no overflow trap.
REQ-006 Memory access: data_sram_en = data_ram_en, data_sram_wen = data_ram_wen, data_sram_addr = ALU result, data_sram_wdata = rt_data; all combinational from the input register.
REQ-007 ex_result SHALL be the ALU result, HI for mfhi (op 0, func 0x10), or LO for mflo (func 0x12); for mfhi/mflo rf_we=1 and rf_waddr=inst[15:11].
REQ-008 ex_id SHALL equal the registered sel_rf_res, so decode can stall on load-use.
REQ-009 Divider FSM states: IDLE, RUN, DONE; div = op 0, func 0x1A (signed); divu = func 0x1B.
REQ-010 IDLE -> RUN on div/divu with nonzero divisor; IDLE -> DONE on zero divisor; RUN performs one restoring-division step per cycle for 32 cycles and then goes to DONE; DONE -> IDLE.
REQ-011 stallreq_for_ex SHALL be 1 in IDLE when div/divu is present and in RUN; it SHALL be 0 in DONE, so the instruction leaves EX at the end of DONE.
REQ-012 Nonzero divisor: stallreq_for_ex is high for 33 cycles. Zero divisor: high for 1 cycle and HI/LO unchanged.
REQ-013 Signed divide SHALL operate on magnitudes. The quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
REQ-014 HI/LO: LO=quotient and HI=remainder, written on the clock edge that ends DONE, only for a nonzero divisor.
REQ-015 An mfhi/mflo directly after div SHALL read the updated HI/LO, because the write completes before it enters EX.
REQ-016 A bubble (all-zero register) SHALL produce rf_we=0, data_sram_en=0, and no divider start.

Reset
REQ-017 With rst=1 at a clock edge, the input register, HI, LO, and the iteration counter SHALL clear to 0 and the FSM SHALL enter IDLE, including mid-RUN (no HI/LO write).
REQ-018 After reset, every output SHALL be 0 except data_sram_addr=0 and ex_result=0 (the ALU result of a zero bubble).

Configuration
REQ-019 Macro EX_DIV_EN: when defined, REQ-009 to REQ-015 are built in. When undefined, there is no FSM, div/divu are treated as no-ops, stallreq_for_ex is tied to 0, and HI/LO are held at 0.

Verification
REQ-020 addu with rs_data=0x7FFFFFFF, rt_data=1 -> ex_result=0x80000000, ex_to_rf_bus={1,rd,0x80000000} in the same cycle.
REQ-021 lw with rs_data=0x1000, imm=0xFFFC -> data_sram_addr=0x0FFC, data_sram_en=1, data_sram_wen=0, ex_id=1.
REQ-022 div with rs=7, rt=0xFFFFFFFE -> stallreq_for_ex high 33 cycles; then LO=0xFFFFFFFD, HI=1; a following mflo returns 0xFFFFFFFD.
REQ-023 divu with divisor 0 and HI=5 -> stall for 1 cycle only, HI stays 5.
REQ-024 rst asserted at RUN cycle 10 -> FSM IDLE and stallreq_for_ex=0 next cycle; HI/LO=0.
REQ-025 stall[2]=1, stall[3]=0 -> next cycle ex_to_mem_bus=0 and data_sram_en=0.
